// File: rtl/line_memory.sv
// Line-granular backing memory below the data cache: one full-line read or write
// at a time, fixed countdown latency, one-cycle ready pulse. Stats ports under LINE_MEM_STATS_EN.
module line_memory #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_DEPTH_LINES = 256,
  parameter int MEM_LATENCY     = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_mem_read_en,
  input  logic                       in_mem_write_en,
  input  logic [31:0]                in_mem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_read_data,
  output logic                       out_mem_ready
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]                out_read_count,
  output logic [31:0]                out_write_count
`endif
);

  localparam int IDX_W = $clog2(MEM_DEPTH_LINES);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       wr_q, wr_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
  logic [CACHE_LINE_SIZE-1:0] rdata_q, rdata_d;

  logic [CACHE_LINE_SIZE-1:0] mem_q [MEM_DEPTH_LINES];

  logic                       req;
  logic [IDX_W-1:0]           req_idx;
  logic                       acc_en;
  logic                       acc_wr;
  logic [IDX_W-1:0]           acc_idx;
  logic [CACHE_LINE_SIZE-1:0] acc_data;
  logic                       unused_addr;

  assign req         = in_mem_read_en | in_mem_write_en;
  assign req_idx     = in_mem_addr[4 +: IDX_W];
  assign unused_addr = ^in_mem_addr;

  // Single-cycle latency bypasses the latched request and accesses straight from the inputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    acc_en   = 1'b0;
    acc_wr   = wr_q;
    acc_idx  = idx_q;
    acc_data = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = in_mem_write_en;
          idx_d   = req_idx;
          wdata_d = in_mem_write_data;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          if (MEM_LATENCY == 1) begin
            state_d  = RESP;
            acc_en   = 1'b1;
            acc_wr   = in_mem_write_en;
            acc_idx  = req_idx;
            acc_data = in_mem_write_data;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          acc_en  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdata_d = (acc_en && !acc_wr) ? mem_q[acc_idx] : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_en && acc_wr && !reset) begin
      mem_q[acc_idx] <= acc_data;
    end
  end

  assign out_mem_ready     = (state_q == RESP);
  assign out_mem_read_data = rdata_q;

`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (acc_en) begin
      if (acc_wr) wr_cnt_q <= wr_cnt_q + 32'd1;
      else        rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign out_read_count  = rd_cnt_q;
  assign out_write_count = wr_cnt_q;
`endif

endmodule
